// File: rtl/counter_uart_reporter_if.sv
// rtl/counter_uart_reporter_if.sv - sample request, counter value and UART report status bundle
interface counter_uart_reporter_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] value_in;
    logic              sample;
    logic              busy;
    logic              tx;
    logic              done;

    modport master (
        output value_in,
        output sample,
        input  busy,
        input  tx,
        input  done
    );

    modport slave (
        input  value_in,
        input  sample,
        output busy,
        output tx,
        output done
    );
endinterface

// File: rtl/counter_uart_reporter.sv
// rtl/counter_uart_reporter.sv - snapshots a counter and sends it as uppercase ASCII hex plus CR LF over 8N1 UART
module counter_uart_reporter #(
    parameter int DATA_W       = 24,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                    clk,
    input  logic                    rst_n,
    counter_uart_reporter_if.slave  bus
);
    localparam int DIGITS = DATA_W / 4;
    localparam int TW     = $clog2(CLKS_PER_BIT);
    localparam int CW     = $clog2(DIGITS + 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_q, bit_d;
    logic [CW-1:0]     char_q, char_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [3:0]        nib;
    logic [7:0]        cur_char;
    logic              last_tick;

    // Current character: hex digits MSB nibble first, then CR, then LF.
    always_comb begin
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (char_q == CW'(i)) begin
                nib = snap_q[DATA_W-1-4*i -: 4];
            end
        end
        cur_char = 8'h0A;
        if (char_q < CW'(DIGITS)) begin
            cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (char_q == CW'(DIGITS)) begin
            cur_char = 8'h0D;
        end
    end

    assign last_tick = (timer_q == TW'(CLKS_PER_BIT - 1));

    // tx is computed from the next state so the line is registered and
    // changes on the same edge the FSM moves.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        char_d  = char_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            timer_d = last_tick ? '0 : timer_q + TW'(1);
        end
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.sample) begin
                    snap_d  = bus.value_in;
                    char_d  = '0;
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (last_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = cur_char[0];
                end
            end
            DATA: begin
                if (last_tick) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_char[bit_d];
                    end
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (char_q == CW'(DIGITS + 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        char_d  = char_q + CW'(1);
                        state_d = START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            snap_q  <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.tx   = tx_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_counter_uart_reporter.sv
// tb/tb_counter_uart_reporter.sv - directed checks of the counter UART reporter at 4 and 2 clocks per bit
module tb_counter_uart_reporter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        smp [2];
    logic [23:0] val [2];

    always #5 clk = ~clk;

    counter_uart_reporter_if #(.DATA_W(24)) if4 ();
    counter_uart_reporter_if #(.DATA_W(24)) if2 ();

    assign if4.sample   = smp[0];
    assign if4.value_in = val[0];
    assign if2.sample   = smp[1];
    assign if2.value_in = val[1];

    counter_uart_reporter #(.DATA_W(24), .CLKS_PER_BIT(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    counter_uart_reporter #(.DATA_W(24), .CLKS_PER_BIT(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          sel;
        logic [23:0] value;
        bit          scramble;
        logic [47:0] hex;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tx_of(input int sel);
        return (sel != 0) ? if2.tx : if4.tx;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? if2.busy : if4.busy;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? if2.done : if4.done;
    endfunction

    task automatic start_report(input int sel, input logic [23:0] v);
        val[sel] = v;
        smp[sel] = 1'b1;
        @(negedge clk);
        smp[sel] = 1'b0;
    endtask

    // Entered on the first cycle tx is low. mode 0: return to idle;
    // mode 1: request the next report on the done cycle; mode 2: sample held by caller.
    task automatic record(input int sel, input logic [47:0] hex, input bit scramble,
                          input int mode, input logic [23:0] next_val);
        int   c = (sel != 0) ? 2 : 4;
        int   n = 80 * c;
        bit   trace [320];
        int   busy_bad = 0;
        int   done_bad = 0;
        logic [7:0] e;
        logic [7:0] got;
        logic       eb;
        bit         bad;
        for (int i = 0; i < n; i++) begin
            trace[i] = tx_of(sel);
            if (busy_of(sel) !== 1'b1) busy_bad++;
            if (done_of(sel) !== 1'b0) done_bad++;
            if (scramble) val[sel] = 24'($urandom);
            @(negedge clk);
        end
        chk("busy_during_report", busy_bad, 0);
        chk("no_early_done", done_bad, 0);
        chk("done_pulse", done_of(sel), 1);
        chk("busy_low_at_done", busy_of(sel), 0);
        chk("tx_high_at_done", tx_of(sel), 1);
        for (int j = 0; j < 8; j++) begin
            e   = (j < 6) ? hex[47-8*j -: 8] : ((j == 6) ? 8'h0D : 8'h0A);
            got = 8'h00;
            bad = 1'b0;
            for (int b = 0; b < 10; b++) begin
                eb = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : e[b-1]);
                for (int t = 0; t < c; t++) begin
                    if (trace[(j*10+b)*c + t] !== eb) bad = 1'b1;
                end
                if (b >= 1 && b <= 8) got[b-1] = trace[(j*10+b)*c + c/2];
            end
            chk($sformatf("char%0d_frame", j), {23'd0, bad, got}, {24'd0, e});
        end
        if (mode == 0) begin
            smp[sel] = 1'b0;
            @(negedge clk);
            chk("idle_busy", busy_of(sel), 0);
            chk("idle_done_cleared", done_of(sel), 0);
            chk("idle_tx", tx_of(sel), 1);
        end else if (mode == 1) begin
            smp[sel] = 1'b1;
            val[sel] = next_val;
            @(negedge clk);
            smp[sel] = 1'b0;
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{sel: 0, value: 24'h00ABCD, scramble: 1'b0, hex: "00ABCD"};
        vecs[1] = '{sel: 1, value: 24'h9A0F5E, scramble: 1'b0, hex: "9A0F5E"};
        vecs[2] = '{sel: 0, value: 24'h123456, scramble: 1'b1, hex: "123456"};
        vecs[3] = '{sel: 1, value: 24'h000000, scramble: 1'b0, hex: "000000"};

        rst_n  = 1'b0;
        smp[0] = 1'b0;
        smp[1] = 1'b0;
        val[0] = 24'h0;
        val[1] = 24'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_tx4", if4.tx, 1);
        chk("reset_busy4", if4.busy, 0);
        chk("reset_done4", if4.done, 0);
        chk("reset_tx2", if2.tx, 1);
        chk("reset_busy2", if2.busy, 0);
        chk("reset_done2", if2.done, 0);
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            start_report(vecs[k].sel, vecs[k].value);
            record(vecs[k].sel, vecs[k].hex, vecs[k].scramble, 0, 24'h0);
        end

        // Back-to-back: sample raised on the done cycle starts the next report one edge later.
        start_report(0, 24'hFFFFFF);
        record(0, "FFFFFF", 1'b0, 1, 24'h000000);
        record(0, "000000", 1'b0, 0, 24'h0);

        // Sample held high: reports repeat with one idle cycle after each done.
        val[0] = 24'h5A5A5A;
        smp[0] = 1'b1;
        @(negedge clk);
        record(0, "5A5A5A", 1'b0, 2, 24'h0);
        record(0, "5A5A5A", 1'b0, 2, 24'h0);
        record(0, "5A5A5A", 1'b0, 2, 24'h0);
        record(0, "5A5A5A", 1'b0, 0, 24'h0);

        // Reset in the middle of the third character's data bits.
        start_report(0, 24'hABCDEF);
        repeat (92) @(negedge clk);
        chk("mid_report_busy", if4.busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_tx", if4.tx, 1);
        chk("abort_busy", if4.busy, 0);
        chk("abort_done", if4.done, 0);
        @(negedge clk);
        chk("abort_stays_idle", if4.tx, 1);
        start_report(0, 24'h13579B);
        record(0, "13579B", 1'b0, 0, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
